// File: rtl/receive.sv
// UART receiver (8N1). Samples the asynchronous rxd line through a two-flop
// synchronizer, reassembles bytes LSB first, and offers each byte on a
// stb/dat/rdy handshake. Framing errors and overruns pulse err for one cycle.
//
// Ports:
//   clk  - system clock, all logic on rising edge
//   rst  - synchronous active-low reset
//   rxd  - serial input, idle high, asynchronous to clk
//   stb  - received byte valid (held until stb && rdy)
//   dat  - received byte, frozen while stb is high
//   rdy  - consumer ready
//   err  - one-cycle pulse on framing error or overrun
module receive #(
    parameter int unsigned BAUDRATE  = 9600,
    parameter int unsigned FREQUENCY = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       stb,
    output logic [7:0] dat,
    input  logic       rdy,
    output logic       err
);

    localparam int unsigned CYCLES = FREQUENCY / BAUDRATE;
    localparam int unsigned CW     = (CYCLES > 4) ? $clog2(CYCLES) : 2;
    localparam logic [CW-1:0] FULL_LD = CW'(CYCLES - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CYCLES / 2 - 1);

    if (CYCLES < 4) begin : g_cycles_check
        $error("receive: FREQUENCY/BAUDRATE must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          done, done_nxt;
    logic          ferr, ferr_nxt;
    logic          sync1, rx;
    logic          expire_c;

    // Two-flop synchronizer; resets to the idle line level
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= rxd;
            rx    <= sync1;
        end
    end

    // Receive state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            done  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            done  <= done_nxt;
            ferr  <= ferr_nxt;
        end
    end

    assign expire_c = (cnt == '0);

    // Next-state logic: every sample is taken at the middle of a bit period
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_LD;
                end
            end
            START: begin
                if (expire_c) begin
                    if (rx) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = FULL_LD;
                        idx_nxt   = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DATA: begin
                if (expire_c) begin
                    shreg_nxt = {rx, shreg[7:1]};
                    cnt_nxt   = FULL_LD;
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            STOP: begin
                if (expire_c) begin
                    if (rx) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        ferr_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WAIT: begin
                // A stuck-low line must go high before a new start is accepted
                if (rx) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output handshake; a completion coinciding with a transfer replaces the byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            stb <= 1'b0;
            dat <= '0;
            err <= 1'b0;
        end else begin
            err <= ferr | (done & stb & ~rdy);
            if (done && (!stb || rdy)) begin
                dat <= shreg;
                stb <= 1'b1;
            end else if (stb && rdy) begin
                stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receive.sv
// Self-checking bench for the UART receiver: table of single frames, random
// back-to-back traffic against a byte-queue model, and hand-written corner
// sequences (latency, overrun, glitch, reset mid-frame).
module tb_receive;

    localparam int unsigned FREQ = 16;
    localparam int unsigned BAUD = 1;
    localparam int unsigned C    = FREQ / BAUD;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       stb;
    logic [7:0] dat;
    logic       rdy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    receive #(.BAUDRATE(BAUD), .FREQUENCY(FREQ)) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .stb(stb),
        .dat(dat),
        .rdy(rdy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: record every completed transfer and every err pulse
    logic [7:0] got[$];
    int         err_cnt = 0;
    always @(negedge clk) begin
        if (stb && rdy) got.push_back(dat);
        if (err) err_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        wait_cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        rxd = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_cyc(C);
        end
        rxd = stop_ok;
        wait_cyc(C);
        if (!stop_ok) begin
            wait_cyc(3 * C);
            rxd = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_bytes;
        int         exp_errs;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] expq[$];
    logic [7:0] v;
    int         base, ebase, n;
    bit         tog_on;

    initial begin
        vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, exp_bytes: 1, exp_errs: 0};
        vecs[1] = '{data: 8'h00, stop_ok: 1'b1, exp_bytes: 1, exp_errs: 0};
        vecs[2] = '{data: 8'hFF, stop_ok: 1'b1, exp_bytes: 1, exp_errs: 0};
        vecs[3] = '{data: 8'h55, stop_ok: 1'b0, exp_bytes: 0, exp_errs: 1};
        vecs[4] = '{data: 8'h81, stop_ok: 1'b1, exp_bytes: 1, exp_errs: 0};
        vecs[5] = '{data: 8'h01, stop_ok: 1'b1, exp_bytes: 1, exp_errs: 0};

        rst = 1'b0;
        rxd = 1'b1;
        rdy = 1'b1;
        wait_cyc(3);
        check("reset_stb", int'(stb), 0);
        check("reset_dat", int'(dat), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b1;
        idle(C);

        // Latency of a single frame, rxd falling edge to stb rising
        base = got.size();
        ebase = err_cnt;
        n = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (n < 400 && !stb) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        idle(2 * C);
        check("latency_in_window", int'(n >= 154 && n <= 156), 1);
        if (n < 154 || n > 156) $display("FAIL latency: got %0d cycles expected 154..156", n);
        check("single_count", got.size() - base, 1);
        if (got.size() > base) check("single_dat", int'(got[base]), 8'hA5);
        check("single_err", err_cnt - ebase, 0);

        // Table of isolated frames
        foreach (vecs[k]) begin
            base = got.size();
            ebase = err_cnt;
            send_frame(vecs[k].data, vecs[k].stop_ok);
            idle(2 * C);
            check($sformatf("vec%0d_count", k), got.size() - base, vecs[k].exp_bytes);
            check($sformatf("vec%0d_err", k), err_cnt - ebase, vecs[k].exp_errs);
            if (vecs[k].exp_bytes == 1 && got.size() > base)
                check($sformatf("vec%0d_dat", k), int'(got[base]), int'(vecs[k].data));
        end

        // Random back-to-back bytes: round 0 with rdy held, round 1 with random rdy
        for (int r = 0; r < 2; r++) begin
            expq.delete();
            base = got.size();
            ebase = err_cnt;
            rdy = 1'b1;
            tog_on = 1'b1;
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        v = 8'($urandom_range(0, 255));
                        expq.push_back(v);
                        send_frame(v, 1'b1);
                    end
                    tog_on = 1'b0;
                end
                begin
                    while (tog_on) begin
                        @(posedge clk);
                        #2;
                        if (r == 1) rdy = 1'($urandom_range(0, 1));
                    end
                end
            join
            rdy = 1'b1;
            idle(3 * C);
            check($sformatf("rand%0d_count", r), got.size() - base, expq.size());
            check($sformatf("rand%0d_err", r), err_cnt - ebase, 0);
            for (int i = 0; i < expq.size(); i++) begin
                if (base + i < got.size())
                    check($sformatf("rand%0d_dat%0d", r, i), int'(got[base + i]), int'(expq[i]));
            end
        end

        // Backpressure and overrun
        rdy = 1'b0;
        base = got.size();
        ebase = err_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(2 * C);
        check("ovr_stb_held", int'(stb), 1);
        check("ovr_dat_held", int'(dat), 8'h3C);
        check("ovr_err", err_cnt - ebase, 1);
        check("ovr_no_xfer", got.size() - base, 0);
        rdy = 1'b1;
        wait_cyc(1);
        check("ovr_stb_fall", int'(stb), 0);
        idle(2 * C);
        check("ovr_count", got.size() - base, 1);
        if (got.size() > base) check("ovr_dat", int'(got[base]), 8'h3C);

        // Glitch shorter than half a bit is rejected
        base = got.size();
        ebase = err_cnt;
        rxd = 1'b0;
        wait_cyc(C / 4);
        idle(2 * C);
        check("glitch_count", got.size() - base, 0);
        check("glitch_err", err_cnt - ebase, 0);
        send_frame(8'h7E, 1'b1);
        idle(2 * C);
        check("glitch_next_count", got.size() - base, 1);
        if (got.size() > base) check("glitch_next_dat", int'(got[base]), 8'h7E);

        // Reset in the middle of data bit 4 of 0xFF
        base = got.size();
        ebase = err_cnt;
        rxd = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            wait_cyc(C);
        end
        rxd = 1'b1;
        wait_cyc(C / 2);
        rst = 1'b0;
        wait_cyc(2);
        check("rstmid_stb", int'(stb), 0);
        check("rstmid_dat", int'(dat), 0);
        check("rstmid_err", int'(err), 0);
        rst = 1'b1;
        idle(2 * C);
        check("rstmid_no_byte", got.size() - base, 0);
        check("rstmid_no_err", err_cnt - ebase, 0);
        send_frame(8'h12, 1'b1);
        idle(2 * C);
        check("rstmid_next_count", got.size() - base, 1);
        if (got.size() > base) check("rstmid_next_dat", int'(got[base]), 8'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
